voice_allocator: RTL and testbench
==================================

// Module: voice_allocator
// PURPOSE
//  Polyphonic voice allocator sitting directly downstream of midi_reader.
//  Consumes validated, channel-filtered MIDI messages and maps note-on/off
//  onto NUM_VOICES voice slots. Drives per-voice gate/note/velocity/trigger
//  to the oscillator/envelope bank. Steals the least-recently-assigned voice
//  when all voices are busy.
// PARAMETERS
//  NUM_VOICES  8  number of voice slots (>=2); index width VIDX_W=$clog2(NUM_VOICES)
// PORTS
//  i_clk_aud    in   1        audio-domain clock
//  i_aud_rst_n  in   1        asynchronous active-low reset
//  i_msg_valid  in   1        one-cycle strobe: i_msg/i_msg_len valid
//  i_msg_len    in   2        message length in bytes (1..3)
//  i_msg        in   3x8      message bytes; [0]=status
//  o_busy       out  1        allocator processing a message
//  o_drop       out  1        1-cycle pulse: message arrived while busy, discarded
//  o_gate       out  NUM_VOICES         per-voice gate (key held)
//  o_trig       out  NUM_VOICES         per-voice 1-cycle (re)trigger pulse
//  o_note       out  NUM_VOICESx7       per-voice note number
//  o_velocity   out  NUM_VOICESx7       per-voice note-on velocity
// BEHAVIOUR
//  - Reset (async): all outputs 0; FSM=IDLE; voice age[i]=i (LRU permutation).
//  - Decode (len==3 only, else ignored): 0x9n vel>0 = NOTE_ON; 0x8n, or
//    0x9n vel==0 = NOTE_OFF; anything else ignored (no state change).
//  - FSM IDLE -> SCAN -> COMMIT -> IDLE. Capture in IDLE on i_msg_valid (cycle T).
//    SCAN examines one voice per cycle, index 0..NUM_VOICES-1. COMMIT updates
//    voice regs; outputs change at edge T+NUM_VOICES+2. Ignored msgs go IDLE at T+1.
//  - o_busy=1 whenever FSM!=IDLE. i_msg_valid while busy -> o_drop pulse, msg lost
//    (MIDI byte spacing >> scan time; drop is a fault indicator only).
//  - NOTE_ON target priority: (a) gated voice with same note -> retrigger;
//    (b) lowest-index voice with gate=0; (c) gated voice with max age (steal).
//  - NOTE_ON commit: gate=1, note, velocity loaded; o_trig[v] pulses 1 cycle.
//  - LRU: on NOTE_ON to voice v, every voice with age<age[v] increments,
//    age[v]=0. Ages stay a permutation of 0..NUM_VOICES-1; no saturation needed.
//  - NOTE_OFF: first (lowest-index) gated voice with matching note -> gate=0;
//    note/velocity held for envelope release. No match -> no change, no error.
//  - Mid-operation reset: aborts scan immediately; no partial commit survives.
// CONFIGURATION
//  SUSTAIN_PEDAL_EN defined: decode 0xBn cc=64. val>=64 sets sustain; NOTE_OFF
//   while sustained sets per-voice sustained flag, gate stays 1. val<64 clears
//   sustain and in COMMIT drops gate of every sustained voice, clears flags.
//   Retrigger of a sustained voice clears its flag.
//  Undefined: CC messages ignored; no sustain state/flags synthesised.
// STRUCTURE
//  - types.svh: MIDI_NOTE_ON=4'h9, MIDI_NOTE_OFF=4'h8, MIDI_CC=4'hB,
//    CC_SUSTAIN=7'd64, voice_t struct {gate, note[6:0], vel[6:0], sustained}.
//  - Sub-module voice_lru: holds age array, reports max-age index, applies
//    LRU update on assign strobe. Decode/FSM/voice regs stay in voice_allocator.
// TESTING
//  1. Reset, 90 3C 64 -> NUM_VOICES+2 cycles later gate[0]=1, note[0]=60,
//     vel[0]=100, trig[0] one-cycle pulse; busy high throughout scan.
//  2. NOTE_ON 60..67 (8 voices), then 90 48 50 -> voice 0 stolen: note[0]=72,
//     trig[0] pulse, gates all 1; next note 73 steals voice 1.
//  3. 90 3C 64 twice -> same voice retriggered, exactly one gate set, 2 trig pulses.
//  4. 90 3C 00 after NOTE_ON 60 -> gate clears, note stays 60; 80 3D 00 -> no change.
//  5. Valid strobe during scan -> o_drop pulse, voice state unchanged; len=2 msg ignored.
//  6. SUSTAIN_PEDAL_EN: B0 40 7F, 90 3C 64, 80 3C 00 -> gate stays 1;
//     B0 40 00 -> gate 0. Assert reset mid-scan -> all outputs 0 immediately.

Source files
------------

// File: rtl/voice_allocator_pkg.sv
// Shared MIDI constants, voice record and message decode for the voice allocator.
// Optional build macro: SUSTAIN_PEDAL_EN (adds sustain-pedal CC decode).
package voice_allocator_pkg;

    localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
    localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
    localparam logic [3:0] MIDI_CC       = 4'hB;
    localparam logic [6:0] CC_SUSTAIN    = 7'd64;

    typedef struct packed {
        logic       gate;
        logic [6:0] note;
        logic [6:0] vel;
        logic       sustained;
    } voice_t;

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_COMMIT} state_e;

    typedef enum logic [2:0] {CMD_NONE, CMD_ON, CMD_OFF, CMD_SUS_ON, CMD_SUS_OFF} cmd_e;

    // Channel nibble is ignored: channel filtering happens upstream.
    function automatic cmd_e decode_msg(input logic [1:0] len, input logic [2:0][7:0] msg);
        cmd_e cmd;
        cmd = CMD_NONE;
        if (len == 2'd3) begin
            case (msg[0][7:4])
                MIDI_NOTE_ON:  cmd = (msg[2][6:0] != 7'd0) ? CMD_ON : CMD_OFF;
                MIDI_NOTE_OFF: cmd = CMD_OFF;
`ifdef SUSTAIN_PEDAL_EN
                MIDI_CC: begin
                    if (msg[1] == {1'b0, CC_SUSTAIN})
                        cmd = (msg[2][6:0] >= 7'd64) ? CMD_SUS_ON : CMD_SUS_OFF;
                end
`endif
                default: cmd = CMD_NONE;
            endcase
        end
        return cmd;
    endfunction

endpackage

// File: rtl/voice_allocator_lru.sv
// Least-recently-assigned tracker: ages form a permutation of 0..NUM_VOICES-1,
// the voice holding the top age is the steal candidate.
module voice_allocator_lru #(
    parameter int NUM_VOICES = 8,
    parameter int VIDX_W     = $clog2(NUM_VOICES)
) (
    input  logic              i_clk_aud,
    input  logic              i_aud_rst_n,
    input  logic              assign_we,
    input  logic [VIDX_W-1:0] assign_idx,
    output logic [VIDX_W-1:0] oldest_idx
);

    logic [NUM_VOICES-1:0][VIDX_W-1:0] age;
    logic [VIDX_W-1:0]                 age_sel;

    assign age_sel = age[assign_idx];

    always_ff @(posedge i_clk_aud or negedge i_aud_rst_n) begin
        if (!i_aud_rst_n) begin
            for (int i = 0; i < NUM_VOICES; i++) age[i] <= VIDX_W'(i);
        end else if (assign_we) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (assign_idx == VIDX_W'(i))
                    age[i] <= '0;
                else if (age[i] < age_sel)
                    age[i] <= age[i] + 1'b1;
            end
        end
    end

    always_comb begin
        oldest_idx = '0;
        for (int i = 0; i < NUM_VOICES; i++)
            if (age[i] == VIDX_W'(NUM_VOICES - 1)) oldest_idx = VIDX_W'(i);
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note-on/off onto NUM_VOICES slots with LRU stealing.
// Optional build macro: SUSTAIN_PEDAL_EN (sustain pedal via CC 64).
module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int NUM_VOICES = 8
) (
    input  logic                         i_clk_aud,
    input  logic                         i_aud_rst_n,
    input  logic                         i_msg_valid,
    input  logic [1:0]                   i_msg_len,
    input  logic [2:0][7:0]              i_msg,
    output logic                         o_busy,
    output logic                         o_drop,
    output logic [NUM_VOICES-1:0]        o_gate,
    output logic [NUM_VOICES-1:0]        o_trig,
    output logic [NUM_VOICES-1:0][6:0]   o_note,
    output logic [NUM_VOICES-1:0][6:0]   o_velocity
);

    localparam int                VIDX_W   = $clog2(NUM_VOICES);
    localparam logic [VIDX_W-1:0] LAST_IDX = VIDX_W'(NUM_VOICES - 1);

    state_e                  state, state_nxt;
    cmd_e                    cmd_q;
    logic [6:0]              note_q, vel_q;
    logic [VIDX_W-1:0]       scan_idx, match_idx, free_idx, oldest_idx, tgt_idx;
    logic                    match_vld, free_vld, lru_we;
    voice_t [NUM_VOICES-1:0] voices, voices_nxt;
    logic [NUM_VOICES-1:0]   trig_q, trig_nxt;
`ifdef SUSTAIN_PEDAL_EN
    logic                    sustain, sustain_nxt;
`endif

    assign o_busy = (state != ST_IDLE);

    always_ff @(posedge i_clk_aud or negedge i_aud_rst_n) begin
        if (!i_aud_rst_n) state <= ST_IDLE;
        else              state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (i_msg_valid) state_nxt = ST_SCAN;
            ST_SCAN: begin
                if (cmd_q == CMD_NONE)      state_nxt = ST_IDLE;
                else if (scan_idx == LAST_IDX) state_nxt = ST_COMMIT;
            end
            ST_COMMIT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Capture in IDLE, then walk one voice per cycle remembering the first
    // gated same-note voice and the first free voice.
    always_ff @(posedge i_clk_aud or negedge i_aud_rst_n) begin
        if (!i_aud_rst_n) begin
            cmd_q     <= CMD_NONE;
            note_q    <= '0;
            vel_q     <= '0;
            scan_idx  <= '0;
            match_vld <= 1'b0;
            match_idx <= '0;
            free_vld  <= 1'b0;
            free_idx  <= '0;
        end else if (state == ST_IDLE) begin
            scan_idx  <= '0;
            match_vld <= 1'b0;
            free_vld  <= 1'b0;
            if (i_msg_valid) begin
                cmd_q  <= decode_msg(i_msg_len, i_msg);
                note_q <= i_msg[1][6:0];
                vel_q  <= i_msg[2][6:0];
            end
        end else if (state == ST_SCAN) begin
            scan_idx <= scan_idx + 1'b1;
            if (!match_vld && voices[scan_idx].gate && voices[scan_idx].note == note_q) begin
                match_vld <= 1'b1;
                match_idx <= scan_idx;
            end
            if (!free_vld && !voices[scan_idx].gate) begin
                free_vld <= 1'b1;
                free_idx <= scan_idx;
            end
        end
    end

    always_comb begin
        voices_nxt = voices;
        trig_nxt   = '0;
        lru_we     = 1'b0;
        tgt_idx    = oldest_idx;
`ifdef SUSTAIN_PEDAL_EN
        sustain_nxt = sustain;
`endif
        if (state == ST_COMMIT) begin
            case (cmd_q)
                CMD_ON: begin
                    if (match_vld)     tgt_idx = match_idx;
                    else if (free_vld) tgt_idx = free_idx;
                    voices_nxt[tgt_idx] = '{gate: 1'b1, note: note_q, vel: vel_q, sustained: 1'b0};
                    trig_nxt[tgt_idx]   = 1'b1;
                    lru_we              = 1'b1;
                end
                CMD_OFF: begin
                    if (match_vld) begin
`ifdef SUSTAIN_PEDAL_EN
                        if (sustain) voices_nxt[match_idx].sustained = 1'b1;
                        else         voices_nxt[match_idx].gate      = 1'b0;
`else
                        voices_nxt[match_idx].gate = 1'b0;
`endif
                    end
                end
`ifdef SUSTAIN_PEDAL_EN
                CMD_SUS_ON: sustain_nxt = 1'b1;
                CMD_SUS_OFF: begin
                    sustain_nxt = 1'b0;
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (voices[i].sustained) begin
                            voices_nxt[i].gate      = 1'b0;
                            voices_nxt[i].sustained = 1'b0;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Output stage: one register between voice state and the oscillator bank.
    always_ff @(posedge i_clk_aud or negedge i_aud_rst_n) begin
        if (!i_aud_rst_n) begin
            voices     <= '0;
            trig_q     <= '0;
            o_trig     <= '0;
            o_gate     <= '0;
            o_note     <= '0;
            o_velocity <= '0;
            o_drop     <= 1'b0;
        end else begin
            voices <= voices_nxt;
            trig_q <= trig_nxt;
            o_trig <= trig_q;
            o_drop <= i_msg_valid && (state != ST_IDLE);
            for (int i = 0; i < NUM_VOICES; i++) begin
                o_gate[i]     <= voices[i].gate;
                o_note[i]     <= voices[i].note;
                o_velocity[i] <= voices[i].vel;
            end
        end
    end

`ifdef SUSTAIN_PEDAL_EN
    always_ff @(posedge i_clk_aud or negedge i_aud_rst_n) begin
        if (!i_aud_rst_n) sustain <= 1'b0;
        else              sustain <= sustain_nxt;
    end
`endif

    voice_allocator_lru #(
        .NUM_VOICES (NUM_VOICES),
        .VIDX_W     (VIDX_W)
    ) u_lru (
        .i_clk_aud   (i_clk_aud),
        .i_aud_rst_n (i_aud_rst_n),
        .assign_we   (lru_we),
        .assign_idx  (tgt_idx),
        .oldest_idx  (oldest_idx)
    );

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: table of messages with hand-computed voice state,
// plus timing, drop, mid-scan reset and (when built with it) sustain sequences.
module tb_voice_allocator;

    localparam int NV = 8;

    logic                 i_clk_aud = 1'b0;
    logic                 i_aud_rst_n;
    logic                 i_msg_valid;
    logic [1:0]           i_msg_len;
    logic [2:0][7:0]      i_msg;
    logic                 o_busy, o_drop;
    logic [NV-1:0]        o_gate, o_trig;
    logic [NV-1:0][6:0]   o_note, o_velocity;

    always #5 i_clk_aud = ~i_clk_aud;

    voice_allocator #(.NUM_VOICES(NV)) dut (
        .i_clk_aud   (i_clk_aud),
        .i_aud_rst_n (i_aud_rst_n),
        .i_msg_valid (i_msg_valid),
        .i_msg_len   (i_msg_len),
        .i_msg       (i_msg),
        .o_busy      (o_busy),
        .o_drop      (o_drop),
        .o_gate      (o_gate),
        .o_trig      (o_trig),
        .o_note      (o_note),
        .o_velocity  (o_velocity)
    );

    typedef struct {
        logic [1:0] len;
        logic [7:0] b0, b1, b2;
        int         v;
        logic [7:0] gate;
        logic [6:0] note;
        logic [6:0] vel;
        logic [7:0] trig;
    } vec_t;

    vec_t tbl[22];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [1:0] len, input logic [7:0] b0, b1, b2,
                                input int v, input logic [7:0] gate, input int note,
                                input int vel, input logic [7:0] trig);
        vec_t r;
        r.len = len; r.b0 = b0; r.b1 = b1; r.b2 = b2; r.v = v;
        r.gate = gate; r.note = 7'(note); r.vel = 7'(vel); r.trig = trig;
        return r;
    endfunction

    task automatic do_reset();
        @(negedge i_clk_aud);
        i_aud_rst_n = 1'b0;
        i_msg_valid = 1'b0;
        repeat (2) @(negedge i_clk_aud);
        i_aud_rst_n = 1'b1;
    endtask

    // Returns at the falling edge right after the capture edge.
    task automatic strobe(input logic [1:0] len, input logic [7:0] b0, b1, b2);
        @(negedge i_clk_aud);
        i_msg_valid = 1'b1;
        i_msg_len   = len;
        i_msg       = {b2, b1, b0};
        @(negedge i_clk_aud);
        i_msg_valid = 1'b0;
    endtask

    task automatic apply(input logic [1:0] len, input logic [7:0] b0, b1, b2,
                         output logic [NV-1:0] seen, output int cnt);
        seen = '0;
        cnt  = 0;
        strobe(len, b0, b1, b2);
        for (int k = 0; k < NV + 4; k++) begin
            seen |= o_trig;
            cnt  += $countones(o_trig);
            @(negedge i_clk_aud);
        end
        seen |= o_trig;
        cnt  += $countones(o_trig);
    endtask

    initial begin
        logic [NV-1:0] seen;
        int            cnt;

        i_aud_rst_n = 1'b0;
        i_msg_valid = 1'b0;
        i_msg_len   = '0;
        i_msg       = '0;

        tbl[0]  = mk(3, 8'h90, 8'h3C, 8'h64, 0, 8'h01, 60, 100, 8'h01);
        tbl[1]  = mk(3, 8'h90, 8'h3C, 8'h64, 0, 8'h01, 60, 100, 8'h01);
        tbl[2]  = mk(3, 8'h90, 8'h3C, 8'h00, 0, 8'h00, 60, 100, 8'h00);
        tbl[3]  = mk(3, 8'h80, 8'h3D, 8'h00, 0, 8'h00, 60, 100, 8'h00);
        tbl[4]  = mk(2, 8'h90, 8'h3E, 8'h64, 0, 8'h00, 60, 100, 8'h00);
        tbl[5]  = mk(3, 8'h90, 8'h3C, 8'h50, 0, 8'h01, 60, 80,  8'h01);
        tbl[6]  = mk(3, 8'h90, 8'h3D, 8'h11, 1, 8'h03, 61, 17,  8'h02);
        tbl[7]  = mk(3, 8'h90, 8'h3E, 8'h12, 2, 8'h07, 62, 18,  8'h04);
        tbl[8]  = mk(3, 8'h90, 8'h3F, 8'h13, 3, 8'h0F, 63, 19,  8'h08);
        tbl[9]  = mk(3, 8'h90, 8'h40, 8'h14, 4, 8'h1F, 64, 20,  8'h10);
        tbl[10] = mk(3, 8'h90, 8'h41, 8'h15, 5, 8'h3F, 65, 21,  8'h20);
        tbl[11] = mk(3, 8'h90, 8'h42, 8'h16, 6, 8'h7F, 66, 22,  8'h40);
        tbl[12] = mk(3, 8'h90, 8'h43, 8'h17, 7, 8'hFF, 67, 23,  8'h80);
        tbl[13] = mk(3, 8'h90, 8'h48, 8'h50, 0, 8'hFF, 72, 80,  8'h01);
        tbl[14] = mk(3, 8'h90, 8'h49, 8'h51, 1, 8'hFF, 73, 81,  8'h02);
        tbl[15] = mk(3, 8'h80, 8'h3E, 8'h00, 2, 8'hFB, 62, 18,  8'h00);
        tbl[16] = mk(3, 8'h90, 8'h4A, 8'h20, 2, 8'hFF, 74, 32,  8'h04);
        tbl[17] = mk(3, 8'h90, 8'h4B, 8'h21, 3, 8'hFF, 75, 33,  8'h08);
        tbl[18] = mk(3, 8'hC0, 8'h05, 8'h00, 3, 8'hFF, 75, 33,  8'h00);
        tbl[19] = mk(3, 8'h80, 8'h48, 8'h00, 0, 8'hFE, 72, 80,  8'h00);
        tbl[20] = mk(3, 8'h80, 8'h49, 8'h40, 1, 8'hFC, 73, 81,  8'h00);
        tbl[21] = mk(3, 8'h91, 8'h4C, 8'h22, 0, 8'hFD, 76, 34,  8'h01);

        do_reset();
        @(negedge i_clk_aud);
        chk("rst_gate", o_gate, 0);
        chk("rst_trig", o_trig, 0);
        chk("rst_note", o_note, 0);
        chk("rst_vel",  o_velocity, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_drop", o_drop, 0);

        // First note: exact commit latency and trigger width.
        strobe(3, 8'h90, 8'h3C, 8'h64);
        for (int k = 0; k <= NV + 3; k++) begin
            if (k <= NV) chk("busy_scan", o_busy, 1);
            if (k == NV + 1) begin
                chk("busy_done", o_busy, 0);
                chk("gate_early", o_gate, 0);
            end
            if (k == NV + 2) begin
                chk("gate_t", o_gate, 8'h01);
                chk("trig_t", o_trig, 8'h01);
                chk("note_t", o_note[0], 60);
                chk("vel_t",  o_velocity[0], 100);
            end
            if (k == NV + 3) begin
                chk("trig_end", o_trig, 0);
                chk("gate_hold", o_gate, 8'h01);
            end
            @(negedge i_clk_aud);
        end

        do_reset();
        for (int i = 0; i < 22; i++) begin
            apply(tbl[i].len, tbl[i].b0, tbl[i].b1, tbl[i].b2, seen, cnt);
            chk($sformatf("v%0d_gate", i), o_gate, tbl[i].gate);
            chk($sformatf("v%0d_note", i), o_note[tbl[i].v], tbl[i].note);
            chk($sformatf("v%0d_vel", i),  o_velocity[tbl[i].v], tbl[i].vel);
            chk($sformatf("v%0d_trig", i), seen, tbl[i].trig);
            chk($sformatf("v%0d_tcnt", i), cnt, $countones(tbl[i].trig));
            chk($sformatf("v%0d_idle", i), o_busy, 0);
        end

        // A strobe during the scan is dropped and leaves no trace.
        do_reset();
        strobe(3, 8'h90, 8'h3C, 8'h64);
        @(negedge i_clk_aud);
        i_msg_valid = 1'b1;
        i_msg       = {8'h64, 8'h3E, 8'h90};
        @(negedge i_clk_aud);
        i_msg_valid = 1'b0;
        chk("drop_pulse", o_drop, 1);
        @(negedge i_clk_aud);
        chk("drop_end", o_drop, 0);
        repeat (NV + 1) @(negedge i_clk_aud);
        chk("drop_gate", o_gate, 8'h01);
        chk("drop_note", o_note[0], 60);

        // Reset in the middle of a scan clears everything and nothing commits.
        strobe(3, 8'h90, 8'h3D, 8'h64);
        repeat (3) @(negedge i_clk_aud);
        #2 i_aud_rst_n = 1'b0;
        #1;
        chk("mrst_gate", o_gate, 0);
        chk("mrst_note", o_note, 0);
        chk("mrst_vel",  o_velocity, 0);
        chk("mrst_busy", o_busy, 0);
        @(negedge i_clk_aud);
        i_aud_rst_n = 1'b1;
        seen = '0;
        for (int k = 0; k < NV + 4; k++) begin
            seen |= o_trig;
            @(negedge i_clk_aud);
        end
        chk("mrst_nocommit", o_gate, 0);
        chk("mrst_notrig", seen, 0);
        apply(3, 8'h90, 8'h3C, 8'h64, seen, cnt);
        chk("mrst_after", o_gate, 8'h01);

`ifdef SUSTAIN_PEDAL_EN
        do_reset();
        apply(3, 8'hB0, 8'h40, 8'h7F, seen, cnt);
        chk("sus_on_gate", o_gate, 0);
        apply(3, 8'h90, 8'h3C, 8'h64, seen, cnt);
        chk("sus_note_on", o_gate, 8'h01);
        apply(3, 8'h80, 8'h3C, 8'h00, seen, cnt);
        chk("sus_held", o_gate, 8'h01);
        apply(3, 8'hB0, 8'h40, 8'h00, seen, cnt);
        chk("sus_release", o_gate, 0);
        chk("sus_note", o_note[0], 60);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
